// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one slow-memory port between the I-cache and the D-cache.
// Simultaneous requests are resolved round-robin. Memory strobes, address and
// write data are registered at the grant edge and held until mem_ready.
// Ready and read data back to the caches are combinational.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  // I-cache side
  input  logic              mem_read_I,
  input  logic              mem_write_I,
  input  logic [ADDR_W-1:0] mem_addr_I,
  input  logic [LINE_W-1:0] mem_wdata_I,
  output logic [LINE_W-1:0] mem_rdata_I,
  output logic              mem_ready_I,
  // D-cache side
  input  logic              mem_read_D,
  input  logic              mem_write_D,
  input  logic [ADDR_W-1:0] mem_addr_D,
  input  logic [LINE_W-1:0] mem_wdata_D,
  output logic [LINE_W-1:0] mem_rdata_D,
  output logic              mem_ready_D,
  // memory side
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_prio;   // 0: D preferred, 1: I preferred
  logic                r_read;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wdata;

  logic                w_act_I;
  logic                w_act_D;
  logic                w_grant_I;
  logic                w_grant_D;

  // A side is active on read or write; a read+write pair is treated as a write.
  assign w_act_I   = mem_read_I | mem_write_I;
  assign w_act_D   = mem_read_D | mem_write_D;
  assign w_grant_D = w_act_D & (~w_act_I | ~r_prio);
  assign w_grant_I = w_act_I & ~w_grant_D;

  // Arbitration FSM: grant in IDLE, hold captured request until mem_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_prio  <= 1'b0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_D) begin
            r_state <= BUSY_D;
            r_prio  <= 1'b1;
            r_write <= mem_write_D;
            r_read  <= mem_read_D & ~mem_write_D;
            r_addr  <= mem_addr_D;
            r_wdata <= mem_wdata_D;
          end else if (w_grant_I) begin
            r_state <= BUSY_I;
            r_prio  <= 1'b0;
            r_write <= mem_write_I;
            r_read  <= mem_read_I & ~mem_write_I;
            r_addr  <= mem_addr_I;
            r_wdata <= mem_wdata_I;
          end
        end
        BUSY_I, BUSY_D: begin
          // Completion forces at least one IDLE cycle before the next grant.
          if (mem_ready) begin
            r_state <= IDLE;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_read  <= 1'b0;
          r_write <= 1'b0;
          r_addr  <= '0;
          r_wdata <= '0;
        end
      endcase
    end
  end

  assign mem_read    = r_read;
  assign mem_write   = r_write;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;

  // Completion is routed to the owner only; read data is shared and qualified by ready.
  assign mem_ready_I = (r_state == BUSY_I) & mem_ready;
  assign mem_ready_D = (r_state == BUSY_D) & mem_ready;
  assign mem_rdata_I = mem_rdata;
  assign mem_rdata_D = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: randomized request rounds, a memory
// model with random latency and spurious idle readies, and a scoreboard
// monitor that checks every grant and completion against expected order.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_read_I, mem_write_I, mem_read_D, mem_write_D;
  logic [AW-1:0] mem_addr_I, mem_addr_D, mem_addr;
  logic [LW-1:0] mem_wdata_I, mem_wdata_D, mem_wdata;
  logic [LW-1:0] mem_rdata_I, mem_rdata_D, mem_rdata;
  logic          mem_ready_I, mem_ready_D, mem_ready;
  logic          mem_read, mem_write;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_I(mem_read_I), .mem_write_I(mem_write_I), .mem_addr_I(mem_addr_I),
    .mem_wdata_I(mem_wdata_I), .mem_rdata_I(mem_rdata_I), .mem_ready_I(mem_ready_I),
    .mem_read_D(mem_read_D), .mem_write_D(mem_write_D), .mem_addr_D(mem_addr_D),
    .mem_wdata_D(mem_wdata_D), .mem_rdata_D(mem_rdata_D), .mem_ready_D(mem_ready_D),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            side;   // 0 = I, 1 = D
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wd;
  } txn_t;

  txn_t expq[$];
  int   total = 0;
  int   bad   = 0;
  bit   prio_m = 1'b0;     // reference round-robin pointer: 0 = D preferred
  bit   mon_off = 1'b1;
  bit   spur_en = 1'b0;
  bit   mem_hold = 1'b0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    return {a, 4'h1, ~a, 4'h2, a ^ 28'h5A5A5A5, 4'h3, a + 28'd7, 4'h4};
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    logic [31:0] t;
    t = $urandom();
    return t[AW-1:0];
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [1:0] rnd_op();
    logic [31:0] v;
    v = $urandom_range(1, 3);
    return v[1:0];
  endfunction

  // Memory model: random latency per transaction, optional spurious idle readies.
  initial begin
    int cnt;
    int lat;
    cnt = 0;
    lat = $urandom_range(0, 6);
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      if (mem_read || mem_write) begin
        if (!mem_hold) begin
          if (cnt >= lat) begin
            mem_ready = 1'b1;
            mem_rdata = line_of(mem_addr);
            cnt = 0;
            lat = $urandom_range(0, 6);
          end else begin
            cnt++;
          end
        end
      end else begin
        cnt = 0;
        if (spur_en && $urandom_range(0, 3) == 0) begin
          mem_ready = 1'b1;
          mem_rdata = rnd_line();
        end
      end
    end
  end

  // Scoreboard monitor
  int            ncyc = 0;
  int            rdy_t = 0;
  bit            prev_stb = 1'b0;
  bit            chk_after = 1'b0;
  bit            b2b = 1'b0;
  logic          s_rd, s_wr;
  logic [AW-1:0] s_addr;
  logic [LW-1:0] s_wd;

  always @(negedge clk) begin
    txn_t cur;
    bit   stb;
    ncyc++;
    stb = mem_read | mem_write;
    if (mon_off) begin
      prev_stb  = 1'b0;
      chk_after = 1'b0;
      b2b       = 1'b0;
    end else begin
      chk("single_owner_ready", 128'(mem_ready_I & mem_ready_D), 128'(0));
      chk("ready_forwarding", 128'(mem_ready_I | mem_ready_D), 128'(stb & mem_ready));
      if (chk_after) begin
        chk("idle_after_ready", 128'(stb), 128'(0));
        chk_after = 1'b0;
      end
      if (stb && !prev_stb) begin
        chk("grant_expected", 128'(expq.size() > 0), 128'(1));
        if (expq.size() > 0) begin
          cur = expq[0];
          chk("grant_write", 128'(mem_write), 128'(cur.wr));
          chk("grant_read", 128'(mem_read), 128'(!cur.wr));
          chk("grant_addr", 128'(mem_addr), 128'(cur.addr));
          chk("grant_wdata", mem_wdata, cur.wd);
        end
        if (b2b) begin
          chk("b2b_gap", 128'(ncyc - rdy_t), 128'(2));
          b2b = 1'b0;
        end
        s_rd = mem_read; s_wr = mem_write; s_addr = mem_addr; s_wd = mem_wdata;
      end else if (stb) begin
        chk("hold_read", 128'(mem_read), 128'(s_rd));
        chk("hold_write", 128'(mem_write), 128'(s_wr));
        chk("hold_addr", 128'(mem_addr), 128'(s_addr));
        chk("hold_wdata", mem_wdata, s_wd);
      end
      if (stb && (mem_ready_I || mem_ready_D)) begin
        chk("ready_expected", 128'(expq.size() > 0), 128'(1));
        if (expq.size() > 0) begin
          cur = expq.pop_front();
          chk("ready_to_D", 128'(mem_ready_D), 128'(cur.side));
          chk("ready_to_I", 128'(mem_ready_I), 128'(!cur.side));
          chk("rdata_I", mem_rdata_I, line_of(cur.addr));
          chk("rdata_D", mem_rdata_D, line_of(cur.addr));
          chk_after = 1'b1;
          if (expq.size() > 0) begin
            b2b   = 1'b1;
            rdy_t = ncyc;
          end
        end
      end
      prev_stb = stb;
    end
  end

  task automatic finish_now();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // One round: chosen caches raise requests together; each holds until its ready.
  task automatic run_round(input bit doI, input bit doD,
                           input logic [1:0] opI, input logic [1:0] opD,
                           input logic [AW-1:0] aI, input logic [AW-1:0] aD,
                           input logic [LW-1:0] wI, input logic [LW-1:0] wD);
    txn_t tI, tD;
    bit   pI, pD, sI, sD, first_D;
    tI = '{1'b0, opI[1], aI, wI};
    tD = '{1'b1, opD[1], aD, wD};
    if (doI && doD) begin
      first_D = !prio_m;
      if (first_D) begin expq.push_back(tD); expq.push_back(tI); end
      else         begin expq.push_back(tI); expq.push_back(tD); end
      prio_m = first_D ? 1'b0 : 1'b1;  // second grant decides the final pointer
    end else if (doD) begin
      first_D = 1'b1;
      expq.push_back(tD);
      prio_m = 1'b1;
    end else begin
      first_D = 1'b0;
      if (doI) expq.push_back(tI);
      prio_m = doI ? 1'b0 : prio_m;
    end
    mem_read_I  = doI & opI[0];
    mem_write_I = doI & opI[1];
    mem_addr_I  = aI;
    mem_wdata_I = wI;
    mem_read_D  = doD & opD[0];
    mem_write_D = doD & opD[1];
    mem_addr_D  = aD;
    mem_wdata_D = wD;
    pI = doI;
    pD = doD;
    @(posedge clk);
    #1;
    chk("grant_latency", 128'(mem_read | mem_write), 128'(doI | doD));
    for (int c = 0; c < 400 && (pI || pD); c++) begin
      @(negedge clk);
      sI = mem_ready_I;
      sD = mem_ready_D;
      @(posedge clk);
      #1;
      if (sI && pI) begin mem_read_I = 1'b0; mem_write_I = 1'b0; pI = 1'b0; end
      if (sD && pD) begin mem_read_D = 1'b0; mem_write_D = 1'b0; pD = 1'b0; end
      // The granted side's inputs wander; the memory bus must not follow them.
      if (first_D && pD) begin
        mem_addr_D = rnd_addr(); mem_wdata_D = rnd_line();
      end else if (!first_D && pI) begin
        mem_addr_I = rnd_addr(); mem_wdata_I = rnd_line();
      end
    end
    if (pI || pD) begin
      chk("round_timeout", 128'(1), 128'(0));
      finish_now();
    end
  endtask

  initial begin
    bit doI, doD;
    rst_n = 1'b0;
    mem_read_I = 1'b0; mem_write_I = 1'b0; mem_addr_I = '0; mem_wdata_I = '0;
    mem_read_D = 1'b0; mem_write_D = 1'b0; mem_addr_D = '0; mem_wdata_D = '0;
    repeat (3) @(posedge clk);
    #2;
    mem_ready = 1'b1;
    #1;
    chk("reset_read", 128'(mem_read), 128'(0));
    chk("reset_write", 128'(mem_write), 128'(0));
    chk("reset_addr", 128'(mem_addr), 128'(0));
    chk("reset_wdata", mem_wdata, 128'(0));
    chk("reset_ready_I", 128'(mem_ready_I), 128'(0));
    chk("reset_ready_D", 128'(mem_ready_D), 128'(0));
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    mon_off = 1'b0;
    @(posedge clk);
    #1;

    // Simultaneous D write and I read after reset: D first, one idle cycle, then I.
    run_round(1'b1, 1'b1, 2'b01, 2'b10, 28'h200, 28'h100, rnd_line(), rnd_line());
    // Single I read.
    run_round(1'b1, 1'b0, 2'b01, 2'b00, 28'h0000040, 28'h0, rnd_line(), '0);
    // Continuous contention: four grants alternate.
    run_round(1'b1, 1'b1, 2'b01, 2'b01, 28'h0000300, 28'h0000400, rnd_line(), rnd_line());
    run_round(1'b1, 1'b1, 2'b10, 2'b10, 28'h0000500, 28'h0000600, rnd_line(), rnd_line());
    // Read and write together issue as a write.
    run_round(1'b1, 1'b0, 2'b11, 2'b00, 28'h0000700, 28'h0, rnd_line(), '0);
    run_round(1'b0, 1'b1, 2'b00, 2'b11, 28'h0, 28'h0000800, '0, rnd_line());

    // Random rounds with spurious idle readies and idle gaps.
    spur_en = 1'b1;
    for (int r = 0; r < 60; r++) begin
      doI = ($urandom_range(0, 2) != 0);
      doD = ($urandom_range(0, 2) != 0);
      if (!doI && !doD) doD = 1'b1;
      run_round(doI, doD, rnd_op(), rnd_op(), rnd_addr(), rnd_addr(), rnd_line(), rnd_line());
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    spur_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a D read.
    mem_hold   = 1'b1;
    mem_read_D = 1'b1;
    mem_addr_D = 28'h0ABCDE0;
    mem_wdata_D = rnd_line();
    expq.push_back('{1'b1, 1'b0, 28'h0ABCDE0, mem_wdata_D});
    @(posedge clk);
    #1;
    chk("rst_test_grant", 128'(mem_read), 128'(1));
    repeat (2) @(posedge clk);
    #2;
    mon_off   = 1'b1;
    mem_ready = 1'b1;
    rst_n     = 1'b0;
    #1;
    chk("async_rst_read", 128'(mem_read), 128'(0));
    chk("async_rst_write", 128'(mem_write), 128'(0));
    chk("async_rst_ready_D", 128'(mem_ready_D), 128'(0));
    chk("async_rst_ready_I", 128'(mem_ready_I), 128'(0));
    chk("async_rst_addr", 128'(mem_addr), 128'(0));
    mem_read_D = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    expq.delete();
    prio_m   = 1'b0;
    mem_hold = 1'b0;
    @(posedge clk);
    #1;
    mon_off = 1'b0;
    @(posedge clk);
    #1;
    // Pointer is back to D-preferred after reset.
    run_round(1'b1, 1'b1, 2'b01, 2'b10, 28'h0000900, 28'h0000A00, rnd_line(), rnd_line());
    repeat (3) @(posedge clk);
    chk("queue_drained", 128'(expq.size()), 128'(0));
    finish_now();
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL global_timeout got=running expected=finished");
    bad++;
    finish_now();
  end

endmodule
